// File: rtl/afu_manager.sv
// Workspace controller: reads conf_size configuration lines from host memory, writes dsm_size DSM
// status lines, then idles in RUN. Define AFU_MGR_CYCLE_CNT_EN to carry a cycle count in DSM word2.
module afu_manager #(
  parameter int ADDR_W  = 48,
  parameter int MDATA_W = 16,
  parameter int DATA_W  = 512
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [63:0]        rst_afus,
  input  logic [63:0]        start_afus,
  input  logic [6:0]         rst_buffer_in_index,
  input  logic [6:0]         rst_buffer_out_index,
  input  logic [63:0]        workspace_addr_base,
  input  logic [15:0]        conf_size,
  input  logic [15:0]        dsm_size,
  input  logic               update_workspace,
  output logic               req_rd_en,
  input  logic               req_rd_available,
  output logic [ADDR_W-1:0]  req_rd_addr,
  output logic [MDATA_W-1:0] req_rd_mdata,
  input  logic               resp_rd_valid,
  input  logic [DATA_W-1:0]  resp_rd_data,
  input  logic [MDATA_W-1:0] resp_rd_mdata,
  input  logic               req_wr_available,
  output logic               req_wr_en,
  output logic [ADDR_W-1:0]  req_wr_addr,
  output logic [MDATA_W-1:0] req_wr_mdata,
  output logic [DATA_W-1:0]  req_wr_data,
  input  logic               resp_wr_valid,
  input  logic [MDATA_W-1:0] resp_wr_mdata,
  output logic [575:0]       info
);
  // Handshake: req_*_en is a one-cycle pulse raised after an edge at which *_available was high;
  // resp_rd_valid / resp_wr_valid are single-cycle strobes that are never back-pressured.
  localparam int LW = ADDR_W - 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_CONF   = 3'd1,
    S_WAIT_CONF = 3'd2,
    S_WR_DSM    = 3'd3,
    S_WAIT_DSM  = 3'd4,
    S_RUN       = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [15:0]       conf_size_q, dsm_size_q;
  logic [15:0]       rd_issued, wr_issued, conf_rx, dsm_ack;
  logic [DATA_W-1:0] last_conf, wr_line;
  logic [6:0]        in_idx_q, out_idx_q;
  logic [LW-1:0]     base_line;
  logic [63:0]       cyc_cnt;
  logic              upd_q, upd_rise, load, restart, issue_rd, issue_wr;
  logic              conf_loaded, dsm_done;
  logic              unused_ok;

  assign base_line = workspace_addr_base[ADDR_W-1:6];
  assign upd_rise  = update_workspace & ~upd_q;
  assign unused_ok = ^{resp_rd_mdata, resp_wr_mdata, workspace_addr_base[5:0],
                       workspace_addr_base[63:ADDR_W]};

  // Zero-sized phases are skipped straight through.
  function automatic state_t entry_state(input logic [15:0] c, input logic [15:0] d);
    if (c != 16'd0)      return S_RD_CONF;
    else if (d != 16'd0) return S_WR_DSM;
    else                 return S_RUN;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    restart   = 1'b0;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    if (!start) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          load      = 1'b1;
          state_nxt = entry_state(conf_size, dsm_size);
        end
        S_RD_CONF: begin
          if (req_rd_available) begin
            issue_rd = 1'b1;
            if (rd_issued == conf_size_q - 16'd1) state_nxt = S_WAIT_CONF;
          end
        end
        S_WAIT_CONF: begin
          if (conf_rx == conf_size_q) state_nxt = (dsm_size_q == 16'd0) ? S_RUN : S_WR_DSM;
        end
        S_WR_DSM: begin
          if (req_wr_available) begin
            issue_wr = 1'b1;
            if (wr_issued == dsm_size_q - 16'd1) state_nxt = S_WAIT_DSM;
          end
        end
        S_WAIT_DSM: begin
          if (dsm_ack == dsm_size_q) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (upd_rise) begin
            load      = 1'b1;
            restart   = 1'b1;
            state_nxt = entry_state(conf_size, dsm_size);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef AFU_MGR_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || state == S_IDLE) cyc_cnt <= '0;
    else                          cyc_cnt <= cyc_cnt + 64'd1;
  end
`else
  assign cyc_cnt = '0;
`endif

  always_comb begin
    wr_line          = '0;
    wr_line[63:0]    = 64'(wr_issued);
    wr_line[127:64]  = start_afus & ~rst_afus;
    wr_line[191:128] = cyc_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_rd_en    <= 1'b0;
      req_rd_addr  <= '0;
      req_rd_mdata <= '0;
      req_wr_en    <= 1'b0;
      req_wr_addr  <= '0;
      req_wr_mdata <= '0;
      req_wr_data  <= '0;
      conf_size_q  <= '0;
      dsm_size_q   <= '0;
      rd_issued    <= '0;
      wr_issued    <= '0;
      conf_rx      <= '0;
      dsm_ack      <= '0;
      last_conf    <= '0;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      upd_q        <= 1'b0;
    end else begin
      upd_q     <= update_workspace;
      in_idx_q  <= rst_buffer_in_index;
      out_idx_q <= rst_buffer_out_index;
      req_rd_en <= issue_rd;
      req_wr_en <= issue_wr;
      if (issue_rd) begin
        req_rd_addr  <= {base_line + LW'(rd_issued), 6'b0};
        req_rd_mdata <= MDATA_W'(rd_issued);
        rd_issued    <= rd_issued + 16'd1;
      end
      if (issue_wr) begin
        req_wr_addr  <= {base_line + LW'(conf_size_q) + LW'(wr_issued), 6'b0};
        req_wr_mdata <= MDATA_W'(16'h8000 | wr_issued);
        req_wr_data  <= wr_line;
        wr_issued    <= wr_issued + 16'd1;
      end
      // Responses are counted in every state, so stragglers after an abort still register.
      if (resp_rd_valid) begin
        conf_rx   <= conf_rx + 16'd1;
        last_conf <= resp_rd_data;
      end
      if (resp_wr_valid) dsm_ack <= dsm_ack + 16'd1;
      if (load) begin
        conf_size_q <= conf_size;
        dsm_size_q  <= dsm_size;
        rd_issued   <= '0;
        wr_issued   <= '0;
        conf_rx     <= '0;
        dsm_ack     <= '0;
      end
      if (restart) last_conf <= '0;
    end
  end

  assign conf_loaded = (state != S_IDLE) && (state != S_RD_CONF) && (conf_rx == conf_size_q);
  assign dsm_done    = ((state == S_WAIT_DSM) || (state == S_RUN)) && (dsm_ack == dsm_size_q);

  assign info = {last_conf, 2'b00, out_idx_q, in_idx_q, dsm_ack, conf_rx, 11'd0,
                 dsm_done, conf_loaded, state};
endmodule

// File: tb/tb_afu_manager.sv
// Bench for afu_manager: expected requests are queued when a run is set up; a negedge monitor
// pops and compares every request the DUT emits, and info is checked against a run-level model.
module tb_afu_manager;
  localparam int AW = 48;
  localparam int MW = 16;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, update_workspace;
  logic [63:0]   rst_afus, start_afus, workspace_addr_base;
  logic [6:0]    rst_buffer_in_index, rst_buffer_out_index;
  logic [15:0]   conf_size, dsm_size;
  logic          req_rd_en, req_rd_available, resp_rd_valid;
  logic [AW-1:0] req_rd_addr, req_wr_addr;
  logic [MW-1:0] req_rd_mdata, resp_rd_mdata, req_wr_mdata, resp_wr_mdata;
  logic [DW-1:0] resp_rd_data, req_wr_data;
  logic          req_wr_available, req_wr_en, resp_wr_valid;
  logic [575:0]  info;

  afu_manager dut (
    .clk(clk), .reset(reset), .start(start), .rst_afus(rst_afus), .start_afus(start_afus),
    .rst_buffer_in_index(rst_buffer_in_index), .rst_buffer_out_index(rst_buffer_out_index),
    .workspace_addr_base(workspace_addr_base), .conf_size(conf_size), .dsm_size(dsm_size),
    .update_workspace(update_workspace), .req_rd_en(req_rd_en),
    .req_rd_available(req_rd_available), .req_rd_addr(req_rd_addr), .req_rd_mdata(req_rd_mdata),
    .resp_rd_valid(resp_rd_valid), .resp_rd_data(resp_rd_data), .resp_rd_mdata(resp_rd_mdata),
    .req_wr_available(req_wr_available), .req_wr_en(req_wr_en), .req_wr_addr(req_wr_addr),
    .req_wr_mdata(req_wr_mdata), .req_wr_data(req_wr_data), .resp_wr_valid(resp_wr_valid),
    .resp_wr_mdata(resp_wr_mdata), .info(info)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+MW-1:0]    rd_exp_q[$];
  logic [AW+MW+DW-1:0] wr_exp_q[$];
  logic [MW-1:0]       wr_tags[$];
  int rd_total = 0, wr_total = 0, rsp_sent = 0, cur_c = 0, avail_mode = 0;
  logic rd_avail_s = 1'b0, wr_avail_s = 1'b0;
  logic [DW-1:0] exp_last = '0;

  always @(posedge clk) begin
    rd_avail_s <= req_rd_available;
    wr_avail_s <= req_wr_available;
  end

  // Availability driver: 0 = always high, 1 = toggling, 2 = random.
  initial begin
    req_rd_available = 1'b1;
    req_wr_available = 1'b1;
    forever begin
      @(negedge clk);
      case (avail_mode)
        0: begin req_rd_available = 1'b1; req_wr_available = 1'b1; end
        1: begin req_rd_available = ~req_rd_available; req_wr_available = ~req_wr_available; end
        default: begin
          req_rd_available = 1'($urandom_range(0, 1));
          req_wr_available = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [AW+MW-1:0]    re;
    logic [AW+MW+DW-1:0] we;
    if (!reset) begin
      if (req_rd_en) begin
        checks++;
        if (!rd_avail_s) begin
          errors++;
          $display("FAIL rd_avail: read issued with available=%0d, required 1", rd_avail_s);
        end
        checks++;
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got addr %h mdata %h, required no read", req_rd_addr, req_rd_mdata);
        end else begin
          re = rd_exp_q.pop_front();
          if ({req_rd_addr, req_rd_mdata} !== re) begin
            errors++;
            $display("FAIL rd_req: got %h required %h", {req_rd_addr, req_rd_mdata}, re);
          end
        end
        rd_total++;
      end
      if (req_wr_en) begin
        checks++;
        if (!wr_avail_s) begin
          errors++;
          $display("FAIL wr_avail: write issued with available=%0d, required 1", wr_avail_s);
        end
        checks++;
        if (req_rd_en) begin
          errors++;
          $display("FAIL rd_wr_same: got both enables 1, required at most one");
        end
        checks++;
        if (rsp_sent != cur_c) begin
          errors++;
          $display("FAIL wr_early: got write after %0d responses, required %0d", rsp_sent, cur_c);
        end
        checks++;
        if (wr_exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr %h mdata %h, required no write", req_wr_addr, req_wr_mdata);
        end else begin
          we = wr_exp_q.pop_front();
`ifdef AFU_MGR_CYCLE_CNT_EN
          we[191:128] = req_wr_data[191:128];
`endif
          if ({req_wr_addr, req_wr_mdata, req_wr_data} !== we) begin
            errors++;
            $display("FAIL wr_req: got %h required %h", {req_wr_addr, req_wr_mdata, req_wr_data}, we);
          end
        end
        wr_tags.push_back(req_wr_mdata);
        wr_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check_val(input string name, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic wait_rd(input int target);
    int k = 0;
    while (rd_total < target && k < 2000) begin tick(1); k++; end
    checks++;
    if (rd_total < target) begin
      errors++;
      $display("FAIL rd_timeout: got %0d reads, required %0d", rd_total, target);
    end
  endtask

  task automatic wait_wr(input int target);
    int k = 0;
    while (wr_total < target && k < 2000) begin tick(1); k++; end
    checks++;
    if (wr_total < target) begin
      errors++;
      $display("FAIL wr_timeout: got %0d writes, required %0d", wr_total, target);
    end
  endtask

  task automatic send_rd(input int tag, input logic [DW-1:0] data);
    resp_rd_valid = 1'b1;
    resp_rd_mdata = MW'(tag);
    resp_rd_data  = data;
    rsp_sent++;
    tick(1);
    resp_rd_valid = 1'b0;
  endtask

  task automatic send_wr(input logic [MW-1:0] tag);
    resp_wr_valid = 1'b1;
    resp_wr_mdata = tag;
    tick(1);
    resp_wr_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_info(input string tag, input int st, input int rx, input int ack,
                            input bit loaded, input bit done, input logic [6:0] ii,
                            input logic [6:0] oi);
    check_val({tag, "_state"}, 576'(info[2:0]), 576'(st));
    check_val({tag, "_loaded"}, 576'(info[3]), 576'(loaded));
    check_val({tag, "_done"}, 576'(info[4]), 576'(done));
    check_val({tag, "_rsvd"}, 576'({info[63:62], info[15:5]}), 576'(0));
    check_val({tag, "_conf_rx"}, 576'(info[31:16]), 576'(rx));
    check_val({tag, "_dsm_ack"}, 576'(info[47:32]), 576'(ack));
    check_val({tag, "_idx"}, 576'(info[61:48]), 576'({oi, ii}));
    check_val({tag, "_last_conf"}, 576'(info[575:64]), 576'(exp_last));
  endtask

  task automatic go_idle();
    start = 1'b0;
    tick(2);
    check_val("idle_state", 576'(info[2:0]), 576'(0));
  endtask

  // One complete load sequence; dir selects reversed responses with 0xBB/0xAA line data.
  task automatic run_seq(input logic [63:0] base, input int c, input int d, input logic [63:0] sa,
                         input logic [63:0] ra, input bit use_upd, input bit dir, input int mode);
    logic [AW-1:0] bb;
    logic [DW-1:0] line_d[$];
    int            order[$];
    logic [MW-1:0] tags[$];
    logic [6:0]    ii, oi;
    int            r0, w0, s;
    avail_mode = mode;
    bb = {base[AW-1:6], 6'b0};
    workspace_addr_base = base;
    conf_size  = 16'(c);
    dsm_size   = 16'(d);
    start_afus = sa;
    rst_afus   = ra;
    ii = 7'($urandom);
    oi = 7'($urandom);
    rst_buffer_in_index  = ii;
    rst_buffer_out_index = oi;
    cur_c = c;
    rsp_sent = 0;
    r0 = rd_total;
    w0 = wr_total;
    wr_tags.delete();
    for (int i = 0; i < c; i++) begin
      rd_exp_q.push_back({bb + AW'(i) * AW'(64), MW'(i)});
      if (dir) line_d.push_back((i == 0) ? {64{8'hBB}} : {64{8'hAA}});
      else     line_d.push_back(rand_line());
      order.push_back(i);
    end
    for (int j = 0; j < d; j++)
      wr_exp_q.push_back({bb + AW'(c + j) * AW'(64), 16'h8000 | 16'(j),
                          320'd0, 64'd0, sa & ~ra, 64'(j)});
    if (use_upd) begin
      update_workspace = 1'b1;
      tick(1);
      update_workspace = 1'b0;
    end else begin
      start = 1'b1;
    end
    if (c == 0 && d == 0) begin
      tick(2);
      check_val("zero_run_fast", 576'(info[2:0]), 576'(5));
    end
    wait_rd(r0 + c);
    if (dir) begin
      for (int k = 0; k < c; k++) order[k] = c - 1 - k;
    end else begin
      for (int k = c - 1; k > 0; k--) begin
        s = $urandom_range(0, k);
        {order[k], order[s]} = {order[s], order[k]};
      end
    end
    for (int k = 0; k < c; k++) begin
      if (!dir) tick($urandom_range(0, 2));
      send_rd(order[k], line_d[order[k]]);
      if (dir && k == 0 && c > 1) begin
        tick(3);
        check_val("dir_wait_state", 576'(info[2:0]), 576'(2));
        check_val("dir_wait_rx", 576'(info[31:16]), 576'(1));
      end
    end
    if (c > 0)        exp_last = line_d[order[c-1]];
    else if (use_upd) exp_last = '0;
    wait_wr(w0 + d);
    tags = wr_tags;
    for (int k = tags.size() - 1; k > 0; k--) begin
      s = $urandom_range(0, k);
      {tags[k], tags[s]} = {tags[s], tags[k]};
    end
    foreach (tags[k]) begin
      tick($urandom_range(0, 2));
      send_wr(tags[k]);
    end
    tick(4);
    check_info("run", 5, c, d, 1'b1, 1'b1, ii, oi);
    check_val("rd_drained", 576'(rd_exp_q.size()), 576'(0));
    check_val("wr_drained", 576'(wr_exp_q.size()), 576'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] late_d;
    int            r0;
    logic [63:0]   base;
    // Reset with active-looking inputs: nothing may move.
    reset = 1'b1;
    start = 1'b1;
    update_workspace = 1'b1;
    rst_afus = 64'($urandom);
    start_afus = 64'($urandom);
    rst_buffer_in_index = 7'h55;
    rst_buffer_out_index = 7'h2A;
    workspace_addr_base = 64'h1000;
    conf_size = 16'd3;
    dsm_size = 16'd2;
    resp_rd_valid = 1'b1;
    resp_rd_mdata = '0;
    resp_rd_data = {16{32'hDEADBEEF}};
    resp_wr_valid = 1'b1;
    resp_wr_mdata = '0;
    avail_mode = 2;
    tick(3);
    check_val("rst_rd_en", 576'(req_rd_en), 576'(0));
    check_val("rst_wr_en", 576'(req_wr_en), 576'(0));
    check_val("rst_rd_req", 576'({req_rd_addr, req_rd_mdata}), 576'(0));
    check_val("rst_wr_req", {req_wr_addr, req_wr_mdata, req_wr_data}, 576'(0));
    check_val("rst_info", info, 576'(0));
    start = 1'b0;
    update_workspace = 1'b0;
    resp_rd_valid = 1'b0;
    resp_wr_valid = 1'b0;
    rst_buffer_in_index = 7'h00;
    rst_buffer_out_index = 7'h00;
    reset = 1'b0;
    tick(3);
    check_val("post_rst_info", info, 576'(0));

    // Directed: two reads answered in reverse order, one DSM write.
    run_seq(64'h1000, 2, 1, 64'($urandom), 64'($urandom), 1'b0, 1'b1, 0);
    go_idle();

    // Toggling availability.
    run_seq({32'($urandom), 32'($urandom)}, 5, 3, 64'($urandom), 64'($urandom), 1'b0, 1'b0, 1);
    go_idle();

    // Zero sizes: last_conf retained on start, cleared by an update restart.
    run_seq(64'h2000, 0, 0, 64'd0, 64'd0, 1'b0, 1'b0, 0);
    run_seq(64'h2000, 0, 0, 64'd0, 64'd0, 1'b1, 1'b0, 0);
    run_seq(64'h3000, 2, 1, 64'($urandom), 64'($urandom), 1'b1, 1'b0, 2);
    go_idle();

    // Abort in RD_CONF after the first of four reads.
    avail_mode = 0;
    workspace_addr_base = 64'h4000;
    conf_size = 16'd4;
    dsm_size = 16'd1;
    cur_c = 4;
    rsp_sent = 0;
    r0 = rd_total;
    for (int i = 0; i < 4; i++) rd_exp_q.push_back({48'h4000 + AW'(i) * AW'(64), MW'(i)});
    start = 1'b1;
    wait_rd(r0 + 1);
    start = 1'b0;
    tick(1);
    check_val("abort_state", 576'(info[2:0]), 576'(0));
    tick(5);
    check_val("abort_no_reads", 576'(rd_total), 576'(r0 + 1));
    rd_exp_q.delete();
    late_d = rand_line();
    send_rd(0, late_d);
    tick(2);
    exp_last = late_d;
    check_val("late_rx", 576'(info[31:16]), 576'(1));
    check_val("late_last_conf", 576'(info[575:64]), 576'(late_d));
    check_val("late_loaded", 576'(info[3]), 576'(0));
    run_seq(64'h5000, 1, 2, 64'hF, 64'h2, 1'b0, 1'b0, 0);

    // Randomized runs, first one near the top of the address space.
    for (int it = 0; it < 6; it++) begin
      if (it == 0) base = 64'hABCD_FFFF_FFFF_FFC5;
      else         base = {32'($urandom), 32'($urandom)};
      if (it % 2 == 0) go_idle();
      run_seq(base, $urandom_range(1, 5), $urandom_range(0, 4), {32'($urandom), 32'($urandom)},
              {32'($urandom), 32'($urandom)}, (it % 2) == 1, 1'b0, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/afu_manager.md
Name: afu_manager

Overview:
- Workspace controller between the CCI host-memory request path and a set of accelerator slots.
- On start, it reads a configuration region of conf_size cache lines from the host workspace.
- It then writes dsm_size status (DSM) lines back and enters a run state.
- It exports a 576-bit info vector for CSR readout.

Parameters:
ADDR_W, 48, byte-address width of req_rd_addr/req_wr_addr (line address plus 6 zero bits)
MDATA_W, 16, metadata tag width
DATA_W, 512, cache-line data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  level enable; low forces IDLE
rst_afus  in  64  per-slot reset mask
start_afus  in  64  per-slot run mask
rst_buffer_in_index  in  7  input-buffer reset index (reported only)
rst_buffer_out_index  in  7  output-buffer reset index (reported only)
workspace_addr_base  in  64  workspace byte base; bits[5:0] ignored, bits above ADDR_W ignored
conf_size  in  16  configuration lines to read
dsm_size  in  16  DSM lines to write
update_workspace  in  1  rising edge while running restarts the load sequence
req_rd_en  out  1  read request valid
req_rd_available  in  1  read channel can accept
req_rd_addr  out  ADDR_W  read byte address
req_rd_mdata  out  MDATA_W  read tag
resp_rd_valid  in  1  read response valid
resp_rd_data  in  DATA_W  read response line
resp_rd_mdata  in  MDATA_W  read response tag
req_wr_available  in  1  write channel can accept
req_wr_en  out  1  write request valid
req_wr_addr  out  ADDR_W  write byte address
req_wr_mdata  out  MDATA_W  write tag
req_wr_data  out  DATA_W  write line
resp_wr_valid  in  1  write ack
resp_wr_mdata  in  MDATA_W  write ack tag
info  out  576  status vector

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- All outputs are registered. On reset:
  - all outputs 0;
  - state IDLE;
  - all counters 0.
- Address arithmetic: B = {workspace_addr_base[ADDR_W-1:6], 6'b0}.
  - Configuration line i is at B + 64*i.
  - DSM line j is at B + 64*(conf_size + j).
  - Arithmetic is modulo 2^ADDR_W.
- States: IDLE(0), RD_CONF(1), WAIT_CONF(2), WR_DSM(3), WAIT_DSM(4), RUN(5).
- IDLE: when start=1, go to RD_CONF.
  - If conf_size=0, go to WR_DSM instead.
  - If dsm_size is also 0, go to RUN.
- RD_CONF: in each cycle with req_rd_available=1, pulse req_rd_en for one cycle.
  - Request line i = 0,1,... with req_rd_mdata=i.
  - After conf_size requests have issued, go to WAIT_CONF.
  - No request is issued in a cycle where req_rd_available=0.
- WAIT_CONF / RD_CONF responses: each resp_rd_valid increments conf_rx.
  - Responses may arrive out of order.
  - The response data is latched into last_conf.
  - When conf_rx equals conf_size, go to WR_DSM, or to RUN if dsm_size=0.
- WR_DSM: in each cycle with req_wr_available=1, issue write j with req_wr_mdata=16'h8000|j.
  - DSM line data: word0 = j zero-extended; word1 = start_afus & ~rst_afus; word2 per Optional Feature; words 3..7 = 0.
  - After dsm_size writes have issued, go to WAIT_DSM.
- WAIT_DSM: each resp_wr_valid increments dsm_ack. When dsm_ack equals dsm_size, go to RUN.
- RUN: idle.
  - A rising edge of update_workspace resets conf_rx, dsm_ack and last_conf, then goes to RD_CONF (or follows the zero-size skips).
- start=0 in any state: go to IDLE next cycle and stop issuing requests.
  - Counters and last_conf are retained.
  - Late responses still increment counters.
- A read and a write are never both issued in the same cycle.
- conf_size and dsm_size are sampled on leaving IDLE or on restart, and held stable internally.
- info layout:
  - [2:0] state
  - [3] conf_loaded (conf_rx==conf_size in or after WAIT_CONF)
  - [4] dsm_done
  - [15:5] 0
  - [31:16] conf_rx
  - [47:32] dsm_ack
  - [54:48] rst_buffer_in_index
  - [61:55] rst_buffer_out_index
  - [63:62] 0
  - [575:64] last_conf

Optional Feature:
- Macro: AFU_MGR_CYCLE_CNT_EN.
- Defined: a 64-bit counter clears on leaving IDLE and increments every non-IDLE cycle; DSM word2 carries its value at request issue.
- Undefined: no counter is built and word2 = 0.

Test Plan:
- Reset -> all outputs 0, info=0, no requests for any input.
- base=0x1000, conf_size=2, dsm_size=1, start=1, avail high -> reads at 0x1000 (mdata 0) and 0x1040 (mdata 1); after 2 responses, write at 0x1080 with mdata 0x8000; after the ack, info[2:0]=5, info[31:16]=2, info[47:32]=1.
- req_rd_available toggling 1/0 -> req_rd_en only in available cycles; exactly conf_size requests total.
- Responses returned in order 1 then 0, with data 0xAA.. then 0xBB.. -> info[575:64]=0xBB..; transition to WR_DSM after the second response.
- conf_size=0, dsm_size=0, start=1 -> RUN within 2 cycles, no requests; then an update_workspace pulse re-evaluates and returns to RUN.
- start dropped in RD_CONF after 1 of 4 reads -> IDLE next cycle, no further reads; start_afus=0xF, rst_afus=0x2 gives DSM word1=0xD in a later run.
